// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Definitions shared by the seven-segment display blocks.
//   DIGIT_W            width of a digit code (one hex/BCD nibble)
//   DEFAULT_MAX_DIGIT  last value of a plain decimal digit
//   dir_e              count direction, encoded to match the 'up' input bit
//   clamp_digit()      saturates a digit code to a caller-supplied maximum
// ---------------------------------------------------------------------------
package display_pkg;

    localparam int DIGIT_W           = 4;
    localparam int DEFAULT_MAX_DIGIT = 9;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Values above max_val collapse onto max_val; everything else passes.
    function automatic logic [DIGIT_W-1:0] clamp_digit(
        input logic [DIGIT_W-1:0] val,
        input logic [DIGIT_W-1:0] max_val
    );
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock by DIV = CLK_HZ/TICK_HZ.
//   clk   in  system clock, rising edge
//   rst   in  synchronous reset, active-high; clears the count
//   en    in  count enable; the count holds while low
//   clr   in  synchronous clear; restarts a full period
//   tick  out strobe, high during the cycle whose edge wraps the count
// The strobe is decoded from the count register so that a consumer can act
// on the very edge that wraps; consumers needing a registered pulse
// register it themselves.
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV  = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
    localparam int PC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PC_W-1:0] LAST = PC_W'((DIV > 0) ? (DIV - 1) : 0);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 1");
        end
    endgenerate

    logic [PC_W-1:0] pc;

    assign tick = en && !clr && !rst && (pc == LAST);

    // Period counter: clear and reset both restart a full DIV-cycle period;
    // with DIV == 1 the single-bit counter stays at zero and every enabled
    // cycle wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (en) begin
            pc <= (pc == LAST) ? '0 : pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
// Up/down modulo-(MAX_DIGIT+1) digit counter driving a seven_segment decoder.
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   en        in   count enable (prescaler and digit hold when low)
//   up        in   1 = increment, 0 = decrement, sampled on the tick cycle
//   load      in   synchronous load of load_val (clamped to MAX_DIGIT)
//   load_val  in   value to load
//   num       out  current digit, registered
//   tick      out  1-cycle pulse on each prescaler wrap
//   carry     out  1-cycle pulse on digit wrap (MAX->0 up, 0->MAX down)
// ---------------------------------------------------------------------------
module bcd_digit_counter
    import display_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int MAX_DIGIT = DEFAULT_MAX_DIGIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] num,
    output logic               tick,
    output logic               carry
);

    localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MAX_DIGIT);

    generate
        if (MAX_DIGIT < 1 || MAX_DIGIT > 15) begin : g_bad_max
            $error("bcd_digit_counter: MAX_DIGIT must be in 1..15");
        end
    endgenerate

    logic               wrap;
    dir_e               dir;
    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W-1:0] nxt;
    logic               wraps;

    // A load clears the prescaler so the next tick is a full period away.
    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (wrap)
    );

    assign dir = dir_e'(up);

    // Next digit for a step. An out-of-range digit is treated as MAX_VAL,
    // which the clamp gives for free.
    always_comb begin
        cur   = clamp_digit(num, MAX_VAL);
        nxt   = cur;
        wraps = 1'b0;
        case (dir)
            DIR_UP: begin
                if (cur == MAX_VAL) begin
                    nxt   = '0;
                    wraps = 1'b1;
                end else begin
                    nxt = cur + DIGIT_W'(1);
                end
            end
            default: begin
                if (cur == '0) begin
                    nxt   = MAX_VAL;
                    wraps = 1'b1;
                end else begin
                    nxt = cur - DIGIT_W'(1);
                end
            end
        endcase
    end

    // Digit, tick and carry registers. Load outranks the prescaler wrap, so
    // a load on a wrap cycle produces neither a step nor a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            num   <= '0;
            tick  <= 1'b0;
            carry <= 1'b0;
        end else if (load) begin
            num   <= clamp_digit(load_val, MAX_VAL);
            tick  <= 1'b0;
            carry <= 1'b0;
        end else if (wrap) begin
            num   <= nxt;
            tick  <= 1'b1;
            carry <= wraps;
        end else begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_counter
// Drives two counters (MAX_DIGIT 9 and 5, DIV = 4) from shared stimulus and
// checks them every cycle against a modular-arithmetic model, plus literal
// checkpoints at hand-computed points of the directed sequence.
// ---------------------------------------------------------------------------
module tb_bcd_digit_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] num9;
    logic       tick9;
    logic       carry9;
    logic [3:0] num5;
    logic       tick5;
    logic       carry5;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = MAX_DIGIT 9, index 1 = MAX_DIGIT 5.
    int mMax[2] = '{9, 5};
    int mNum[2];
    int mPhase[2];
    int mTick[2];
    int mCarry[2];
    bit mValid = 1'b0;

    always #5 clk = ~clk;

    bcd_digit_counter #(.CLK_HZ(4), .TICK_HZ(1), .MAX_DIGIT(9)) dut9 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .num(num9), .tick(tick9), .carry(carry9)
    );

    bcd_digit_counter #(.CLK_HZ(4), .TICK_HZ(1), .MAX_DIGIT(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .num(num5), .tick(tick5), .carry(carry5)
    );

    // Behavioural model: phase counts enabled cycles since the last clear;
    // the digit moves modulo (max+1) whenever a full period has elapsed.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mTick[k]  = 0;
            mCarry[k] = 0;
            if (rst) begin
                mNum[k]   = 0;
                mPhase[k] = 0;
            end else if (load) begin
                mNum[k]   = (int'(load_val) > mMax[k]) ? mMax[k] : int'(load_val);
                mPhase[k] = 0;
            end else if (en) begin
                mPhase[k] = mPhase[k] + 1;
                if (mPhase[k] == DIV) begin
                    mPhase[k] = 0;
                    mTick[k]  = 1;
                    if (up) begin
                        mNum[k]   = (mNum[k] + 1) % (mMax[k] + 1);
                        mCarry[k] = (mNum[k] == 0) ? 1 : 0;
                    end else begin
                        mNum[k]   = (mNum[k] + mMax[k]) % (mMax[k] + 1);
                        mCarry[k] = (mNum[k] == mMax[k]) ? 1 : 0;
                    end
                end
            end
        end
        if (rst) mValid = 1'b1;
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (mValid) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] aNum;
                logic       aTick;
                logic       aCarry;
                aNum   = (k == 0) ? num9 : num5;
                aTick  = (k == 0) ? tick9 : tick5;
                aCarry = (k == 0) ? carry9 : carry5;
                total++;
                if (aNum !== 4'(mNum[k]) || aTick !== 1'(mTick[k]) ||
                    aCarry !== 1'(mCarry[k])) begin
                    bad++;
                    $display("[TB] FAIL model_max%0d t=%0t: got num=%0d tick=%b carry=%b want num=%0d tick=%0d carry=%0d",
                             mMax[k], $time, aNum, aTick, aCarry, mNum[k], mTick[k], mCarry[k]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic u,
                                 input logic l, input logic [3:0] lv);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = lv;
    endtask

    task automatic tickClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal checkpoint: pins both the DUT and the model to a hand value.
    task automatic checkOutput(input string name, input int k, input int eNum,
                               input int eTick, input int eCarry);
        logic [3:0] aNum;
        logic       aTick;
        logic       aCarry;
        aNum   = (k == 0) ? num9 : num5;
        aTick  = (k == 0) ? tick9 : tick5;
        aCarry = (k == 0) ? carry9 : carry5;
        total++;
        if (aNum !== 4'(eNum) || aTick !== 1'(eTick) || aCarry !== 1'(eCarry)) begin
            bad++;
            $display("[TB] FAIL %s dut: got num=%0d tick=%b carry=%b want num=%0d tick=%0d carry=%0d",
                     name, aNum, aTick, aCarry, eNum, eTick, eCarry);
        end
        total++;
        if (mNum[k] != eNum || mTick[k] != eTick || mCarry[k] != eCarry) begin
            bad++;
            $display("[TB] FAIL %s model: got num=%0d tick=%0d carry=%0d want num=%0d tick=%0d carry=%0d",
                     name, mNum[k], mTick[k], mCarry[k], eNum, eTick, eCarry);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        tickClk(2);
        checkOutput("reset9", 0, 0, 0, 0);
        checkOutput("reset5", 1, 0, 0, 0);

        // Count up from reset.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tickClk(3);
        checkOutput("pre_first_tick", 0, 0, 0, 0);
        tickClk(1);
        checkOutput("first_tick", 0, 1, 1, 0);
        tickClk(1);
        checkOutput("tick_one_cycle", 0, 1, 0, 0);
        tickClk(19);
        checkOutput("max5_wrap", 1, 0, 1, 1);
        checkOutput("max9_at6", 0, 6, 1, 0);
        tickClk(12);
        checkOutput("max9_at9", 0, 9, 1, 0);
        checkOutput("max5_at3", 1, 3, 1, 0);
        tickClk(4);
        checkOutput("up_wrap", 0, 0, 1, 1);
        checkOutput("max5_at4", 1, 4, 1, 0);
        tickClk(1);
        checkOutput("carry_one_cycle", 0, 0, 0, 0);

        // Count down after loading 0.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        tickClk(1);
        checkOutput("load_zero", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tickClk(4);
        checkOutput("down_wrap9", 0, 9, 1, 1);
        checkOutput("down_wrap5", 1, 5, 1, 1);
        tickClk(4);
        checkOutput("down_8", 0, 8, 1, 0);
        tickClk(32);
        checkOutput("down_0", 0, 0, 1, 0);
        checkOutput("down5_2", 1, 2, 1, 0);

        // Enable pause with two cycles into the period.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tickClk(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tickClk(10);
        checkOutput("paused", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tickClk(1);
        checkOutput("resume_1", 0, 0, 0, 0);
        tickClk(1);
        checkOutput("resume_tick", 0, 1, 1, 0);

        // Load of an out-of-range value on a wrap cycle.
        tickClk(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
        tickClk(1);
        checkOutput("load_clamp9", 0, 9, 0, 0);
        checkOutput("load_clamp5", 1, 5, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd12);
        tickClk(3);
        checkOutput("post_load_wait", 0, 9, 0, 0);
        tickClk(1);
        checkOutput("post_load_wrap9", 0, 0, 1, 1);
        checkOutput("post_load_wrap5", 1, 0, 1, 1);

        // Reset mid-period at num=5, pc=3.
        tickClk(23);
        checkOutput("before_rst", 0, 5, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tickClk(1);
        checkOutput("mid_rst", 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tickClk(3);
        checkOutput("rst_no_early_tick", 0, 0, 0, 0);
        tickClk(1);
        checkOutput("rst_first_tick", 0, 1, 1, 0);

        // Direction only matters on the tick cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tickClk(3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tickClk(1);
        checkOutput("dir_on_tick", 0, 2, 1, 0);
        tickClk(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
